// File: rtl/matriz_pkg.sv
// Shared constants and types for the 7x5 LED matrix scan controller.
// The optional MATRIZ_BLANK_EN feature is configured in varredura_matriz.
package matriz_pkg;

    localparam int NUM_COL = 5;
    localparam int NUM_LIN = 7;
    localparam int COL_W   = 3;

    localparam logic [COL_W-1:0] COL_MAX  = 3'd4;
    localparam logic [COL_W-1:0] COL_ZERO = 3'd0;

    typedef logic [NUM_LIN-1:0] coluna_t;
    typedef coluna_t [NUM_COL-1:0] quadro_t;

    localparam quadro_t QUADRO_RST = {(NUM_COL*NUM_LIN){1'b0}};

    // Column sequence 0..4 wraps back to 0; codes 5..7 are never produced.
    function automatic logic [COL_W-1:0] proxima_coluna(input logic [COL_W-1:0] col);
        logic [COL_W-1:0] prox;
        if (col >= COL_MAX) begin
            prox = COL_ZERO;
        end else begin
            prox = col + 3'd1;
        end
        return prox;
    endfunction

endpackage

// File: rtl/divisor_tick.sv
// Parameterised prescaler: counts 0..DIV-1, wraps, and flags the wrap cycle
// with a registered one-cycle tick aligned to count == DIV-1.
module divisor_tick #(
    parameter int DIV   = 4,
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    output logic [CNT_W-1:0] contagem,
    output logic             tick
);

    localparam logic [CNT_W-1:0] ULTIMO    = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] PENULTIMO = CNT_W'(DIV - 2);
    localparam logic [CNT_W-1:0] UM        = CNT_W'(1);
    localparam logic [CNT_W-1:0] ZERO      = CNT_W'(0);

    logic [CNT_W-1:0] contagem_prox_s;
    logic             tick_prox_s;

    // Next count and next tick; tick is pre-computed so it lines up with the last count.
    always_comb begin
        contagem_prox_s = contagem;
        tick_prox_s     = 1'b0;
        if (contagem == ULTIMO) begin
            contagem_prox_s = ZERO;
            tick_prox_s     = 1'b0;
        end else begin
            contagem_prox_s = contagem + UM;
            tick_prox_s     = (contagem == PENULTIMO);
        end
    end

    // Prescaler state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            contagem <= ZERO;
            tick     <= 1'b0;
        end else begin
            contagem <= contagem_prox_s;
            tick     <= tick_prox_s;
        end
    end

endmodule

// File: rtl/varredura_matriz.sv
// Scan controller for the 7x5 LED matrix: column index, enable and a double-buffered frame.
// Define MATRIZ_BLANK_EN to blank enable for the first BLANK_CICLOS cycles of every column.
module varredura_matriz
    import matriz_pkg::*;
#(
    parameter int DIV_COLUNA   = 50000,
    parameter int BLANK_CICLOS = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_LIN-1:0]  mapa_in0,
    input  logic [NUM_LIN-1:0]  mapa_in1,
    input  logic [NUM_LIN-1:0]  mapa_in2,
    input  logic [NUM_LIN-1:0]  mapa_in3,
    input  logic [NUM_LIN-1:0]  mapa_in4,
    input  logic                carregar,
    output logic                pendente,
    output logic [COL_W-1:0]    contador,
    output logic                enable,
    output logic [NUM_LIN-1:0]  mapa0,
    output logic [NUM_LIN-1:0]  mapa1,
    output logic [NUM_LIN-1:0]  mapa2,
    output logic [NUM_LIN-1:0]  mapa3,
    output logic [NUM_LIN-1:0]  mapa4,
    output logic                fim_quadro
);

    localparam int CNT_W = (DIV_COLUNA > 2) ? $clog2(DIV_COLUNA) : 1;

    logic [CNT_W-1:0] contagem_s;
    logic             tick_s;
    logic             fronteira_s;
    logic [COL_W-1:0] contador_prox_s;
    logic             enable_prox_s;
    logic             pendente_prox_s;
    quadro_t          mapa_in_s;
    quadro_t          pend_r;
    quadro_t          pend_prox_s;
    quadro_t          ativo_r;
    quadro_t          ativo_prox_s;

    divisor_tick #(
        .DIV   (DIV_COLUNA),
        .CNT_W (CNT_W)
    ) u_divisor (
        .clk      (clk),
        .reset    (reset),
        .contagem (contagem_s),
        .tick     (tick_s)
    );

    assign mapa_in_s = {mapa_in4, mapa_in3, mapa_in2, mapa_in1, mapa_in0};

    assign mapa0 = ativo_r[0];
    assign mapa1 = ativo_r[1];
    assign mapa2 = ativo_r[2];
    assign mapa3 = ativo_r[3];
    assign mapa4 = ativo_r[4];

    // Column advance, blanking, and frame swap decisions for the next edge.
    always_comb begin
        fronteira_s     = tick_s && (contador == COL_MAX);
        contador_prox_s = contador;
        enable_prox_s   = 1'b1;
        pendente_prox_s = pendente;
        pend_prox_s     = pend_r;
        ativo_prox_s    = ativo_r;

        if (tick_s) begin
            contador_prox_s = proxima_coluna(contador);
        end else begin
            contador_prox_s = contador;
        end

`ifdef MATRIZ_BLANK_EN
        // Enable tracks the prescaler value the next cycle will show.
        if (tick_s) begin
            enable_prox_s = (BLANK_CICLOS <= 0);
        end else begin
            enable_prox_s = ({{(32-CNT_W){1'b0}}, contagem_s} + 32'd1) >= BLANK_CICLOS;
        end
`else
        enable_prox_s = 1'b1;
`endif

        // The swap reads the old pending buffer even if a capture lands on the same edge.
        if (fronteira_s && pendente) begin
            ativo_prox_s = pend_r;
        end else begin
            ativo_prox_s = ativo_r;
        end

        if (carregar) begin
            pend_prox_s     = mapa_in_s;
            pendente_prox_s = 1'b1;
        end else if (fronteira_s) begin
            pend_prox_s     = pend_r;
            pendente_prox_s = 1'b0;
        end else begin
            pend_prox_s     = pend_r;
            pendente_prox_s = pendente;
        end
    end

    // Output and buffer registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            contador   <= COL_ZERO;
            enable     <= 1'b0;
            fim_quadro <= 1'b0;
            pendente   <= 1'b0;
            pend_r     <= QUADRO_RST;
            ativo_r    <= QUADRO_RST;
        end else begin
            contador   <= contador_prox_s;
            enable     <= enable_prox_s;
            fim_quadro <= fronteira_s;
            pendente   <= pendente_prox_s;
            pend_r     <= pend_prox_s;
            ativo_r    <= ativo_prox_s;
        end
    end

endmodule

// File: tb/tb_varredura_matriz.sv
// Self-checking bench for varredura_matriz with DIV_COLUNA=4, BLANK_CICLOS=1.
// Honours MATRIZ_BLANK_EN for the enable expectation.
module tb_varredura_matriz;

    localparam int DIV   = 4;
    localparam int BLANK = 1;
    localparam int FRAME = 5 * DIV;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             carregar = 1'b0;
    logic [4:0][6:0]  din = '0;
    logic             pendente;
    logic [2:0]       contador;
    logic             enable;
    logic [6:0]       m0, m1, m2, m3, m4;
    logic             fim_quadro;
    logic [4:0][6:0]  act;

    int tests = 0;
    int fails = 0;

    // Reference model: k = rising edges since reset release.
    int              k = 0;
    logic [4:0][6:0] m_act = '0;
    logic [4:0][6:0] m_buf = '0;
    logic            m_pend = 1'b0;

    assign act = {m4, m3, m2, m1, m0};

    always #5 clk = ~clk;

    varredura_matriz #(.DIV_COLUNA(DIV), .BLANK_CICLOS(BLANK)) dut (
        .clk(clk), .reset(reset),
        .mapa_in0(din[0]), .mapa_in1(din[1]), .mapa_in2(din[2]),
        .mapa_in3(din[3]), .mapa_in4(din[4]),
        .carregar(carregar), .pendente(pendente), .contador(contador),
        .enable(enable),
        .mapa0(m0), .mapa1(m1), .mapa2(m2), .mapa3(m3), .mapa4(m4),
        .fim_quadro(fim_quadro)
    );

    function automatic logic [2:0] exp_cont();
        return 3'((k / DIV) % 5);
    endfunction

    function automatic logic exp_fim();
        return (k > 0) && (k % FRAME == 0);
    endfunction

    function automatic logic exp_en();
`ifdef MATRIZ_BLANK_EN
        return (k % DIV) >= BLANK;
`else
        return k >= 1;
`endif
    endfunction

    function automatic logic [4:0][6:0] rnd_frame();
        logic [4:0][6:0] r;
        for (int i = 0; i < 5; i++) r[i] = 7'($urandom_range(127));
        return r;
    endfunction

    task automatic apply_reset();
        reset = 1'b1;
        carregar = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        k = 0;
        m_act = '0;
        m_buf = '0;
        m_pend = 1'b0;
    endtask

    task automatic step(input logic c, input logic [4:0][6:0] d);
        carregar = c;
        din = d;
        @(posedge clk);
        k++;
        if ((k % FRAME == 0) && m_pend) begin
            m_act = m_buf;
            m_pend = 1'b0;
        end
        if (c) begin
            m_buf = d;
            m_pend = 1'b1;
        end
        @(negedge clk);
        carregar = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        tests++; if (contador !== 3'd0) begin fails++; $display("FAIL reset_cont got %0d exp 0", contador); end
        tests++; if (enable !== 1'b0) begin fails++; $display("FAIL reset_en got %b exp 0", enable); end
        tests++; if (act !== 35'd0) begin fails++; $display("FAIL reset_maps got %h exp 0", act); end
        tests++; if (pendente !== 1'b0) begin fails++; $display("FAIL reset_pend got %b exp 0", pendente); end
        tests++; if (fim_quadro !== 1'b0) begin fails++; $display("FAIL reset_fim got %b exp 0", fim_quadro); end
    endtask

    task automatic test_scan();
        apply_reset();
        for (int i = 0; i < 40; i++) begin
            step(1'b0, '0);
            tests++; if (contador !== exp_cont()) begin fails++; $display("FAIL scan_cont k=%0d got %0d exp %0d", k, contador, exp_cont()); end
            tests++; if (fim_quadro !== exp_fim()) begin fails++; $display("FAIL scan_fim k=%0d got %b exp %b", k, fim_quadro, exp_fim()); end
            tests++; if (enable !== exp_en()) begin fails++; $display("FAIL scan_en k=%0d got %b exp %b", k, enable, exp_en()); end
            tests++; if (act !== 35'd0) begin fails++; $display("FAIL scan_maps k=%0d got %h exp 0", k, act); end
        end
    endtask

    task automatic test_load();
        logic [4:0][6:0] f;
        f = {7'h43, 7'h71, 7'h45, 7'h0C, 7'h04};
        apply_reset();
        while (k < 6) step(1'b0, '0);
        step(1'b1, f);
        tests++; if (pendente !== 1'b1) begin fails++; $display("FAIL load_pend got %b exp 1", pendente); end
        while (k < FRAME - 1) begin
            step(1'b0, '0);
            tests++; if (act !== 35'd0) begin fails++; $display("FAIL load_early k=%0d got %h exp 0", k, act); end
        end
        step(1'b0, '0);
        tests++; if (act !== f) begin fails++; $display("FAIL load_swap got %h exp %h", act, f); end
        tests++; if (pendente !== 1'b0) begin fails++; $display("FAIL load_pendclr got %b exp 0", pendente); end
        tests++; if (fim_quadro !== 1'b1) begin fails++; $display("FAIL load_fim got %b exp 1", fim_quadro); end
    endtask

    task automatic test_double_load();
        logic [4:0][6:0] a, b;
        a = rnd_frame();
        b = rnd_frame() ^ 35'h1;
        while (k < FRAME + 5) step(1'b0, '0);
        step(1'b1, a);
        while (k < FRAME + 10) step(1'b0, '0);
        step(1'b1, b);
        while (k < 2 * FRAME) step(1'b0, '0);
        tests++; if (act !== b) begin fails++; $display("FAIL double_swap got %h exp %h", act, b); end
        tests++; if (pendente !== 1'b0) begin fails++; $display("FAIL double_pend got %b exp 0", pendente); end
    endtask

    task automatic test_boundary_load();
        logic [4:0][6:0] b, c;
        b = rnd_frame();
        c = ~b;
        while (k < 2 * FRAME + 5) step(1'b0, '0);
        step(1'b1, b);
        while (k < 3 * FRAME - 1) step(1'b0, '0);
        step(1'b1, c);
        tests++; if (act !== b) begin fails++; $display("FAIL bnd_old got %h exp %h", act, b); end
        tests++; if (pendente !== 1'b1) begin fails++; $display("FAIL bnd_pend got %b exp 1", pendente); end
        tests++; if (fim_quadro !== 1'b1) begin fails++; $display("FAIL bnd_fim got %b exp 1", fim_quadro); end
        while (k < 4 * FRAME) step(1'b0, '0);
        tests++; if (act !== c) begin fails++; $display("FAIL bnd_next got %h exp %h", act, c); end
        tests++; if (pendente !== 1'b0) begin fails++; $display("FAIL bnd_pendclr got %b exp 0", pendente); end
    endtask

    task automatic test_reset_mid();
        while ((k % FRAME) != 13) step(1'b0, '0);
        step(1'b1, rnd_frame());
        tests++; if (contador !== 3'd3) begin fails++; $display("FAIL mid_precont got %0d exp 3", contador); end
        tests++; if (pendente !== 1'b1) begin fails++; $display("FAIL mid_prepend got %b exp 1", pendente); end
        #2 reset = 1'b1;
        #1;
        tests++; if (contador !== 3'd0) begin fails++; $display("FAIL mid_cont got %0d exp 0", contador); end
        tests++; if (enable !== 1'b0) begin fails++; $display("FAIL mid_en got %b exp 0", enable); end
        tests++; if (act !== 35'd0) begin fails++; $display("FAIL mid_maps got %h exp 0", act); end
        tests++; if (pendente !== 1'b0) begin fails++; $display("FAIL mid_pend got %b exp 0", pendente); end
        apply_reset();
    endtask

    task automatic test_random();
        logic c;
        for (int i = 0; i < 300; i++) begin
            c = ($urandom_range(5) == 0);
            step(c, rnd_frame());
            tests++; if (contador !== exp_cont()) begin fails++; $display("FAIL rnd_cont k=%0d got %0d exp %0d", k, contador, exp_cont()); end
            tests++; if (enable !== exp_en()) begin fails++; $display("FAIL rnd_en k=%0d got %b exp %b", k, enable, exp_en()); end
            tests++; if (fim_quadro !== exp_fim()) begin fails++; $display("FAIL rnd_fim k=%0d got %b exp %b", k, fim_quadro, exp_fim()); end
            tests++; if (pendente !== m_pend) begin fails++; $display("FAIL rnd_pend k=%0d got %b exp %b", k, pendente, m_pend); end
            tests++; if (act !== m_act) begin fails++; $display("FAIL rnd_maps k=%0d got %h exp %h", k, act, m_act); end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_load();
        test_double_load();
        test_boundary_load();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
